// File: rtl/cmp_flag_unit_if.sv
// Request/result bundle for the nibble-serial compare flag unit.
// The master drives the opcode, operands and controls; the slave returns the flag and status.
interface cmp_flag_unit_if;
  logic [4:0]  alu_control;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flag_clr;
  logic [1:0]  flag;
  logic        busy;
  logic        done;

  modport master (
    output alu_control, start, op_a, op_b, flag_clr,
    input  flag, busy, done
  );

  modport slave (
    input  alu_control, start, op_a, op_b, flag_clr,
    output flag, busy, done
  );
endinterface

// File: rtl/cmp_flag_unit.sv
// Nibble-serial magnitude comparator producing the 2-bit flag used by conditional MOV.
// Scans from the most significant nibble down and stops at the first difference.
module cmp_flag_unit (
  input  logic            clk,
  input  logic            reset,
  cmp_flag_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  localparam logic [4:0] OP_CMP  = 5'b01100;
  localparam logic [4:0] OP_CMPU = 5'b01101;

  localparam logic [1:0] FLAG_NONE    = 2'b00;
  localparam logic [1:0] FLAG_EQUAL   = 2'b01;
  localparam logic [1:0] FLAG_LESS    = 2'b10;
  localparam logic [1:0] FLAG_GREATER = 2'b11;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  flag_q, flag_d;

  logic        valid_op;
  logic        is_signed;
  logic [3:0]  nib_a;
  logic [3:0]  nib_b;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    flag_d    = flag_q;
    valid_op  = (bus.alu_control == OP_CMP) || (bus.alu_control == OP_CMPU);
    is_signed = (bus.alu_control == OP_CMP);
    nib_a     = a_q[{idx_q, 2'b00} +: 4];
    nib_b     = b_q[{idx_q, 2'b00} +: 4];

    unique case (state_q)
      IDLE: begin
        if (bus.flag_clr) flag_d = FLAG_NONE;
        if (bus.start && valid_op) begin
          // Flipping both sign bits maps two's-complement order onto unsigned order.
          a_d     = is_signed ? {~bus.op_a[31], bus.op_a[30:0]} : bus.op_a;
          b_d     = is_signed ? {~bus.op_b[31], bus.op_b[30:0]} : bus.op_b;
          idx_d   = 3'd7;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (nib_a != nib_b) begin
          flag_d  = (nib_a > nib_b) ? FLAG_GREATER : FLAG_LESS;
          state_d = DONE;
        end else if (idx_q == 3'd0) begin
          flag_d  = FLAG_EQUAL;
          state_d = DONE;
        end else begin
          idx_d   = idx_q - 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 3'd7;
      a_q     <= '0;
      b_q     <= '0;
      flag_q  <= FLAG_NONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      flag_q  <= flag_d;
    end
  end

  assign bus.flag = flag_q;
  assign bus.busy = (state_q == SCAN);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_cmp_flag_unit.sv
// Directed bench for cmp_flag_unit: a behavioural model built on plain signed/unsigned
// comparison and a leading-equal-nibble count is checked against the DUT every cycle.
module tb_cmp_flag_unit;

  localparam logic [4:0] OP_CMP  = 5'b01100;
  localparam logic [4:0] OP_CMPU = 5'b01101;
  localparam logic [4:0] OP_BAD  = 5'b01110;

  logic clk = 1'b0;
  logic reset;

  cmp_flag_unit_if bus ();

  cmp_flag_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int busy_cnt    = 0;
  int done_cnt    = 0;
  bit chk_en      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the result is the plain ordering of the operands; the duration is fixed by
  // how many nibbles match from the top before the first difference.
  function automatic logic [1:0] model_flag(input logic [4:0] code, input logic [31:0] a,
                                            input logic [31:0] b);
    logic lt, gt;
    if (code == OP_CMP) begin
      lt = $signed(a) < $signed(b);
      gt = $signed(a) > $signed(b);
    end else begin
      lt = a < b;
      gt = a > b;
    end
    if (lt)      return 2'b10;
    else if (gt) return 2'b11;
    else         return 2'b01;
  endfunction

  function automatic int leading_equal(input logic [31:0] a, input logic [31:0] b);
    int j = 0;
    for (int i = 7; i >= 0; i--) begin
      if (a[i*4 +: 4] != b[i*4 +: 4]) break;
      j++;
    end
    if (j == 8) j = 7;
    return j;
  endfunction

  int         m_rem    = 0;
  logic       m_done   = 1'b0;
  logic [1:0] m_flag   = 2'b00;
  logic [1:0] m_result = 2'b00;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_flag = 2'b00;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_flag = m_result;
        m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else begin
      if (bus.flag_clr) m_flag = 2'b00;
      if (bus.start && (bus.alu_control == OP_CMP || bus.alu_control == OP_CMPU)) begin
        m_result = model_flag(bus.alu_control, bus.op_a, bus.op_b);
        m_rem    = leading_equal(bus.op_a, bus.op_b) + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("flag", {30'd0, bus.flag}, {30'd0, m_flag});
      check("busy", {31'd0, bus.busy}, {31'd0, m_rem > 0});
      check("done", {31'd0, bus.done}, {31'd0, m_done});
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
    end
  end

  // Called just after a falling edge; returns on the falling edge after the start edge.
  task automatic issue(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                       input logic clr);
    bus.alu_control = code;
    bus.op_a        = a;
    bus.op_b        = b;
    bus.flag_clr    = clr;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.flag_clr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.done) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("settle", {31'd0, bus.busy | bus.done}, 32'd0);
  endtask

  task automatic run_test(input string name, input logic [4:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic clr, input logic [1:0] exp_flag,
                          input int exp_busy);
    busy_cnt = 0;
    done_cnt = 0;
    issue(code, a, b, clr);
    wait_idle();
    check({name, "_flag"},  {30'd0, bus.flag}, {30'd0, exp_flag});
    check({name, "_busy"},  busy_cnt, exp_busy);
    check({name, "_done"},  done_cnt, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b0;
    bus.alu_control = '0;
    bus.start       = 1'b0;
    bus.op_a        = '0;
    bus.op_b        = '0;
    bus.flag_clr    = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    check("rst_flag", {30'd0, bus.flag}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);

    run_test("eq42",    OP_CMPU, 32'd42,         32'd42,         1'b0, 2'b01, 8);
    run_test("early",   OP_CMPU, 32'h9000_0000,  32'h1000_0000,  1'b0, 2'b11, 1);
    run_test("s_m1_1",  OP_CMP,  32'hFFFF_FFFF,  32'd1,          1'b0, 2'b10, 1);
    run_test("u_m1_1",  OP_CMPU, 32'hFFFF_FFFF,  32'd1,          1'b0, 2'b11, 1);
    run_test("low_nib", OP_CMP,  32'd55,         32'd57,         1'b0, 2'b10, 8);
    run_test("s_neg",   OP_CMP,  32'h8000_0000,  32'h7FFF_FFFF,  1'b0, 2'b10, 1);
    run_test("mid",     OP_CMPU, 32'h1234_5678,  32'h1234_0678,  1'b0, 2'b11, 5);

    // Start and flag_clr during SCAN are ignored; operands changing mid-scan do not matter.
    run_test("pre11",   OP_CMPU, 32'd9,          32'd3,          1'b0, 2'b11, 8);
    busy_cnt = 0;
    done_cnt = 0;
    issue(OP_CMPU, 32'd42, 32'd43, 1'b0);
    bus.op_a     = 32'd1;
    bus.op_b     = 32'd2;
    bus.start    = 1'b1;
    bus.flag_clr = 1'b1;
    @(negedge clk);
    check("hold_flag", {30'd0, bus.flag}, 32'd3);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.flag_clr = 1'b0;
    wait_idle();
    check("ign_flag", {30'd0, bus.flag}, 32'd2);
    check("ign_busy", busy_cnt, 32'd8);
    check("ign_done", done_cnt, 32'd1);

    // flag_clr in IDLE.
    bus.flag_clr = 1'b1;
    @(negedge clk);
    bus.flag_clr = 1'b0;
    check("clr_idle", {30'd0, bus.flag}, 32'd0);

    // Invalid opcode leaves the FSM idle and the flag untouched.
    run_test("pre_bad", OP_CMPU, 32'h9000_0000,  32'h1000_0000,  1'b0, 2'b11, 1);
    busy_cnt = 0;
    issue(OP_BAD, 32'd1, 32'd2, 1'b0);
    repeat (3) @(negedge clk);
    check("bad_busy", busy_cnt, 32'd0);
    check("bad_flag", {30'd0, bus.flag}, 32'd3);

    // flag_clr together with a valid start: cleared first, then overwritten.
    run_test("clr_st",  OP_CMP,  32'd3,          32'd3,          1'b1, 2'b01, 8);

    // Mid-scan reset abandons the compare.
    done_cnt = 0;
    issue(OP_CMPU, 32'd88, 32'd88, 1'b0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("mrst_flag", {30'd0, bus.flag}, 32'd0);
    check("mrst_busy", {31'd0, bus.busy}, 32'd0);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    check("mrst_done", done_cnt, 32'd0);

    // A start is accepted on the first rising edge after reset deasserts.
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    issue(OP_CMPU, 32'd5, 32'd3, 1'b0);
    check("post_rst_busy", {31'd0, bus.busy}, 32'd1);
    wait_idle();
    check("post_rst_flag", {30'd0, bus.flag}, 32'd3);
    check("post_rst_done", done_cnt, 32'd1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
